// File: rtl/imsic_msi_pkg.sv
// Shared types for the IMSIC MSI injector: request record, FSM states,
// the AXI request/response structs it drives, and the target address helper.
package imsic_msi_pkg;

  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [AXI_ADDR_W-1:0] PAGE_SIZE   = 64'h1000;
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            BURST_INCR  = 2'b01;
  localparam logic [2:0]            SIZE_4B     = 3'd2;
  localparam logic [AXI_STRB_W-1:0] STRB_LOW32  = 8'h0F;

  // Fields are generously sized; the top zero-extends its narrower ports.
  localparam int MSI_FIELD_W = 16;

  typedef struct packed {
    logic [MSI_FIELD_W-1:0] imsic;
    logic [MSI_FIELD_W-1:0] file;
    logic [MSI_FIELD_W-1:0] eiid;
  } msi_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } msi_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } msi_axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } msi_axi_resp_t;

  // seteipnum_le of the target file: M files live in their own region,
  // S and VS files share one per-hart stride with one page per file.
  function automatic logic [AXI_ADDR_W-1:0] msi_addr(
    input logic [AXI_ADDR_W-1:0] m_base,
    input logic [AXI_ADDR_W-1:0] m_stride,
    input logic [AXI_ADDR_W-1:0] s_base,
    input logic [AXI_ADDR_W-1:0] s_stride,
    input logic [AXI_ADDR_W-1:0] imsic,
    input logic [AXI_ADDR_W-1:0] file
  );
    if (file == '0) begin
      return m_base + imsic * m_stride;
    end
    return s_base + imsic * s_stride + (file - 64'd1) * PAGE_SIZE;
  endfunction

endpackage

// File: rtl/imsic_msi_injector_fifo.sv
// Request buffer: power-of-two depth circular FIFO. Full/empty come from the
// occupancy count only, so a pop never frees a slot for a push in the same cycle.
module fifo_v3 #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imsic_msi_injector.sv
// Buffered MSI injector: filters and queues {imsic, file, eiid} requests and
// turns each into a single-beat AXI write to the target file's seteipnum_le.
module imsic_msi_injector
  import imsic_msi_pkg::*;
#(
  parameter int unsigned NR_IMSICS             = 4,
  parameter int unsigned NR_VS_FILES_PER_IMSIC = 1,
  parameter int unsigned NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
  parameter int unsigned NR_SRC                = 64,
  parameter int unsigned FIFO_DEPTH            = 4,
  parameter int unsigned AXI_ADDR_WIDTH        = 64,
  parameter int unsigned AXI_DATA_WIDTH        = 64,
  parameter int unsigned AXI_ID_WIDTH          = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] M_BASE   = 'h2400_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] M_STRIDE = 'h1000,
  parameter logic [AXI_ADDR_WIDTH-1:0] S_BASE   = 'h2800_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] S_STRIDE = 'h8000,
  parameter type axi_req_t                      = msi_axi_req_t,
  parameter type axi_resp_t                     = msi_axi_resp_t,
  parameter int unsigned CNT_W                  = 16,
  localparam int IMSIC_W = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
  localparam int FILE_W  = $clog2(NR_INTP_FILES),
  localparam int EIID_W  = $clog2(NR_SRC)
) (
  input  logic               i_clk,
  input  logic               ni_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [IMSIC_W-1:0] i_imsic,
  input  logic [FILE_W-1:0]  i_file,
  input  logic [EIID_W-1:0]  i_eiid,
  output axi_req_t           o_req,
  input  axi_resp_t          i_resp,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_sent_cnt,
  output logic [CNT_W-1:0]   o_err_cnt,
  output logic [CNT_W-1:0]   o_drop_cnt
);

  logic       fifo_full;
  logic       fifo_empty;
  logic       req_ok;
  logic       accept;
  logic       push;
  logic       drop;
  logic       pop;
  msi_req_t   push_data;
  msi_req_t   pop_data;

  msi_state_e                state;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      b_ready_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]          sent_cnt;
  logic [CNT_W-1:0]          err_cnt;
  logic [CNT_W-1:0]          drop_cnt;
  logic                      aw_pending;
  logic                      w_pending;

  // Out-of-range requests still complete the handshake; they are only counted.
  assign req_ok = (i_eiid != '0)
               && (32'(i_eiid) < NR_SRC)
               && (32'(i_file) < NR_INTP_FILES)
               && (32'(i_imsic) < NR_IMSICS);

  assign o_ready = !fifo_full;
  assign accept  = i_valid && o_ready;
  assign push    = accept && req_ok;
  assign drop    = accept && !req_ok;
  assign pop     = (state == IDLE) && !fifo_empty;
  assign o_busy  = !fifo_empty || (state != IDLE);

  always_comb begin
    push_data       = '0;
    push_data.imsic = MSI_FIELD_W'(i_imsic);
    push_data.file  = MSI_FIELD_W'(i_file);
    push_data.eiid  = MSI_FIELD_W'(i_eiid);
  end

  fifo_v3 #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(msi_req_t))
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (ni_rst),
    .push     (push),
    .data_in  (push_data),
    .pop      (pop),
    .data_out (pop_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A channel is still pending if its valid is up and not taken this cycle.
  assign aw_pending = aw_valid_q && !i_resp.aw_ready;
  assign w_pending  = w_valid_q && !i_resp.w_ready;

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state      <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sent_cnt   <= '0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            addr_q     <= msi_addr(M_BASE, M_STRIDE, S_BASE, S_STRIDE,
                                   64'(pop_data.imsic), 64'(pop_data.file));
            data_q     <= AXI_DATA_WIDTH'(pop_data.eiid);
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (aw_valid_q && i_resp.aw_ready) begin
            aw_valid_q <= 1'b0;
          end
          if (w_valid_q && i_resp.w_ready) begin
            w_valid_q <= 1'b0;
          end
          if (!aw_pending && !w_pending) begin
            b_ready_q <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (i_resp.b_valid) begin
            b_ready_q <= 1'b0;
            state     <= IDLE;
            if (i_resp.b.resp == RESP_OKAY) begin
              if (sent_cnt != '1) sent_cnt <= sent_cnt + CNT_W'(1);
            end else begin
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload fields are gated by their valid so the bus reads all-zero when idle.
  always_comb begin
    o_req = '0;
    if (aw_valid_q) begin
      o_req.aw.id    = AXI_ID_WIDTH'(0);
      o_req.aw.addr  = addr_q;
      o_req.aw.len   = 8'd0;
      o_req.aw.size  = SIZE_4B;
      o_req.aw.burst = BURST_INCR;
    end
    o_req.aw_valid = aw_valid_q;
    if (w_valid_q) begin
      o_req.w.data = data_q;
      o_req.w.strb = STRB_LOW32;
      o_req.w.last = 1'b1;
    end
    o_req.w_valid = w_valid_q;
    o_req.b_ready = b_ready_q;
  end

  assign o_sent_cnt = sent_cnt;
  assign o_err_cnt  = err_cnt;
  assign o_drop_cnt = drop_cnt;

  logic unused_resp;
  assign unused_resp = ^{i_resp.ar_ready, i_resp.r_valid, i_resp.r, i_resp.b.id};

endmodule

// File: tb/tb_imsic_msi_injector.sv
// Directed bench for imsic_msi_injector: table of single requests plus
// hand-written sequences for backpressure, split handshakes, saturation and reset.
module tb_imsic_msi_injector;
  import imsic_msi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          valid = 1'b0;
  logic [1:0]    imsic = '0;
  logic [1:0]    file  = '0;
  logic [5:0]    eiid  = '0;
  logic          ready;
  logic          busy;
  msi_axi_req_t  req;
  msi_axi_resp_t resp;
  logic [15:0]   sent_cnt;
  logic [15:0]   err_cnt;
  logic [15:0]   drop_cnt;

  logic       aw_ready_en = 1'b1;
  logic       w_ready_en  = 1'b1;
  logic [1:0] bresp_val   = 2'b00;
  logic       b_valid_q;
  logic       got_aw;
  logic       got_w;

  int n_vec  = 0;
  int n_fail = 0;
  logic [15:0] exp_sent = '0;
  logic [15:0] exp_err  = '0;
  logic [15:0] exp_drop = '0;

  logic [127:0] exp_q[$];
  logic [80:0]  aw_q[$];
  logic [72:0]  w_q[$];

  imsic_msi_injector dut (
    .i_clk      (clk),
    .ni_rst     (rst_n),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_imsic    (imsic),
    .i_file     (file),
    .i_eiid     (eiid),
    .o_req      (req),
    .i_resp     (resp),
    .o_busy     (busy),
    .o_sent_cnt (sent_cnt),
    .o_err_cnt  (err_cnt),
    .o_drop_cnt (drop_cnt)
  );

  // ---------------- slave model ----------------
  always_comb begin
    resp          = '0;
    resp.aw_ready = aw_ready_en;
    resp.w_ready  = w_ready_en;
    resp.b_valid  = b_valid_q;
    resp.b.resp   = bresp_val;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q <= 1'b0;
      got_aw    <= 1'b0;
      got_w     <= 1'b0;
    end else begin
      if (b_valid_q && req.b_ready) begin
        b_valid_q <= 1'b0;
      end else if (got_aw && got_w && !b_valid_q) begin
        b_valid_q <= 1'b1;
        got_aw    <= 1'b0;
        got_w     <= 1'b0;
      end
      if (req.aw_valid && resp.aw_ready) got_aw <= 1'b1;
      if (req.w_valid && resp.w_ready)   got_w  <= 1'b1;
    end
  end

  // Monitor: valid & ready seen at negedge means a handshake at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req.aw_valid && resp.aw_ready)
        aw_q.push_back({req.aw.id, req.aw.len, req.aw.size, req.aw.burst, req.aw.addr});
      if (req.w_valid && resp.w_ready)
        w_q.push_back({req.w.strb, req.w.last, req.w.data});
    end
  end

  // ---------------- checker / driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int im, input int fi, input int ei);
    int n;
    n = 0;
    @(negedge clk);
    valid = 1'b1;
    imsic = im[1:0];
    file  = fi[1:0];
    eiid  = ei[5:0];
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("send_timeout", ready, 1);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    logic [80:0]  a;
    logic [72:0]  w;
    logic [127:0] e;
    check("aw_count", aw_q.size(), exp_q.size());
    check("w_count", w_q.size(), exp_q.size());
    while (exp_q.size() > 0 && aw_q.size() > 0 && w_q.size() > 0) begin
      a = aw_q.pop_front();
      w = w_q.pop_front();
      e = exp_q.pop_front();
      check("aw_addr", a[63:0], e[127:64]);
      check("aw_attr", a[80:64], {4'd0, 8'd0, 3'd2, 2'b01});
      check("w_data", w[63:0], e[63:0]);
      check("w_strb_last", w[72:64], {8'h0F, 1'b1});
    end
    exp_q.delete();
    aw_q.delete();
    w_q.delete();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_sent"}, sent_cnt, exp_sent);
    check({tag, "_err"}, err_cnt, exp_err);
    check({tag, "_drop"}, drop_cnt, exp_drop);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          imsic;
    int          file;
    int          eiid;
    bit          drop;
    logic [63:0] addr;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, 0, 5,  1'b0, 64'h2400_2000, 64'h5};
    vecs[1] = '{1, 2, 63, 1'b0, 64'h2800_9000, 64'h3F};
    vecs[2] = '{3, 1, 1,  1'b0, 64'h2801_8000, 64'h1};
    vecs[3] = '{0, 0, 17, 1'b0, 64'h2400_0000, 64'h11};
    vecs[4] = '{1, 1, 0,  1'b1, 64'h0, 64'h0};
    vecs[5] = '{2, 0, 64, 1'b1, 64'h0, 64'h0}; // 64 wraps to 0 on the 6-bit port
    vecs[6] = '{0, 3, 4,  1'b1, 64'h0, 64'h0};
    vecs[7] = '{3, 3, 9,  1'b1, 64'h0, 64'h0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req_zero", (req == '0), 1);
    check_counters("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: accept at edge n, valids up after n+1, idle after n+4
    exp_q.push_back({64'h2400_2000, 64'h5});
    send(2, 0, 5);
    check("lat_n_awvalid", req.aw_valid, 0);
    @(posedge clk); #1;
    check("lat_n1_valids", {req.aw_valid, req.w_valid}, 2'b11);
    repeat (2) @(posedge clk); #1;
    check("lat_n3_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_n4_busy", busy, 0);
    wait_idle();
    drain();
    exp_sent++;
    check_counters("lat");

    // Table of single requests
    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].drop) exp_q.push_back({vecs[i].addr, vecs[i].data});
      send(vecs[i].imsic, vecs[i].file, vecs[i].eiid);
      if (vecs[i].drop) exp_drop++;
      else exp_sent++;
      wait_idle();
      drain();
      check_counters("vec");
    end

    // Backpressure: AW held off, six back-to-back requests
    @(posedge clk); #1 aw_ready_en = 1'b0;
    exp_q.push_back({64'h2400_0000, 64'hA});
    exp_q.push_back({64'h2800_8000, 64'hB});
    exp_q.push_back({64'h2801_1000, 64'hC});
    exp_q.push_back({64'h2400_3000, 64'hD});
    exp_q.push_back({64'h2800_0000, 64'hE});
    exp_q.push_back({64'h2800_9000, 64'hF});
    send(0, 0, 10);
    send(1, 1, 11);
    send(2, 2, 12);
    send(3, 0, 13);
    check("bp_ready_before_full", ready, 1);
    send(0, 1, 14);
    check("bp_ready_full", ready, 0);
    aw_ready_en = 1'b1;
    send(1, 2, 15);
    wait_idle();
    drain();
    exp_sent = exp_sent + 16'd6;
    check_counters("bp");

    // W completes three cycles ahead of AW, slave answers SLVERR
    @(posedge clk); #1;
    aw_ready_en = 1'b0;
    bresp_val   = 2'b10;
    exp_q.push_back({64'h2801_9000, 64'h21});
    send(3, 2, 33);
    repeat (4) @(posedge clk); #1;
    check("split_w_first", {req.aw_valid, req.w_valid}, 2'b10);
    aw_ready_en = 1'b1;
    wait_idle();
    drain();
    exp_err++;
    check_counters("split");

    // Error counter saturation
    @(negedge clk);
    force dut.err_cnt = 16'hFFFF;
    #1 release dut.err_cnt;
    exp_q.push_back({64'h2800_0000, 64'h2});
    send(0, 1, 2);
    wait_idle();
    drain();
    exp_err = 16'hFFFF;
    check_counters("sat");
    bresp_val = 2'b00;

    // Asynchronous reset in the middle of a write
    @(posedge clk); #1;
    aw_ready_en = 1'b0;
    w_ready_en  = 1'b0;
    send(1, 0, 7);
    @(posedge clk); #1;
    check("mid_valids_up", {req.aw_valid, req.w_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valids", {req.aw_valid, req.w_valid, req.b_ready}, 3'b000);
    check("arst_ready", ready, 1);
    check("arst_busy", busy, 0);
    exp_sent = '0;
    exp_err  = '0;
    exp_drop = '0;
    check_counters("arst");
    aw_ready_en = 1'b1;
    w_ready_en  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_req_zero", (req == '0), 1);
    drain();

    // Clean transaction after reset
    exp_q.push_back({64'h2801_0000, 64'h28});
    send(2, 1, 40);
    wait_idle();
    drain();
    exp_sent++;
    check_counters("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
